inc_dec_arb: RTL
================

INC_DEC_ARB -- requirements
Module: inc_dec_arb

Interface
REQ-001 Parameter: N, default 4, operand/result width in bits; SHALL support N >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready.
REQ-006 Port: req0_in  input  N  requester 0 operand.
REQ-007 Port: req0_mode  input  1  requester 0 op: 0 = increment, 1 = decrement.
REQ-008 Port: req1_valid, req1_ready, req1_in, req1_mode  same directions/widths/meaning as REQ-004..007, for requester 1.
REQ-009 Port: res_valid  output  1  result register holds an unconsumed result.
REQ-010 Port: res_ready  input  1  consumer accepts result when res_valid&res_ready.
REQ-011 Port: res_out  output  N  result, modulo 2^N.
REQ-012 Port: res_id  output  1  requester that issued the result (0/1).
REQ-013 Port: res_wrap  output  1  operation wrapped (inc of all-ones or dec of zero).

Function
REQ-014 Block SHALL contain exactly one inc_dec instance (width N), shared by both requesters; no other adder/subtractor.
REQ-015 FSM SHALL have two states: IDLE (result register empty) and HOLD (result register full).
REQ-016 In IDLE: grant SHALL go to the single valid requester; if both valid, to the requester selected by priority pointer ptr.
REQ-017 reqX_ready SHALL be high only in IDLE and only for the granted requester; combinational from valid inputs, ptr and state.
REQ-018 On grant edge: res_out <= inc_dec(reqX_in, reqX_mode); res_id <= X; res_wrap <= wrap condition; state -> HOLD; ptr <= 1-X.
REQ-019 Latency: request accepted at edge k SHALL present res_valid=1 with its result from edge k+1.
REQ-020 In HOLD: res_valid=1; res_out/res_id/res_wrap SHALL stay stable; both reqX_ready=0.
REQ-021 HOLD with res_ready=1 SHALL return to IDLE at the next edge; no new grant in that same cycle (max throughput one op per 2 cycles).
REQ-022 res_ready while IDLE SHALL be ignored; res_valid=0 in IDLE.
REQ-023 Arithmetic: increment = (in+1) mod 2^N, decrement = (in-1) mod 2^N; res_wrap=1 only for inc of 2^N-1 or dec of 0.
REQ-024 ptr SHALL change only on a grant; a lone valid requester SHALL be granted regardless of ptr.
REQ-025 Requester deasserting valid without handshake SHALL not change state or ptr.

Reset
REQ-026 rst=1 SHALL asynchronously force: state=IDLE, ptr=0, res_valid=0, res_out=0, res_id=0, res_wrap=0.
REQ-027 Reset asserted in HOLD SHALL discard the held result; no handshake completes in that cycle.
REQ-028 After rst deasserts, first edge with any valid request SHALL grant normally (ptr=0 priority to req0).

Verification (N=4)
REQ-029 Single inc: req0 in=0000 mode=0 -> res_valid next cycle, res_out=0001, res_id=0, res_wrap=0.
REQ-030 Wrap: req1 in=1111 mode=0 -> res_out=0000, res_wrap=1; req1 in=0000 mode=1 -> res_out=1111, res_wrap=1.
REQ-031 Contention: both valid continuously, res_ready=1 -> grants alternate 0,1,0,1 (res_id sequence), each result correct.
REQ-032 Back-pressure: res_ready=0 for 5 cycles in HOLD -> res_out/res_id stable, both reqX_ready=0; release -> IDLE next edge.
REQ-033 Reset mid-op: rst pulsed in HOLD -> res_valid=0, res_out=0 immediately; next grant goes to req0 when both valid.
REQ-034 Bench SHALL compare every accepted op against a reference model (in+/-1 mod 16, wrap) and report mismatches.

Source files
------------

// File: rtl/inc_dec_arb.sv
// Two-requester arbiter sharing one increment/decrement unit. A grant loads a
// one-entry result register, which stays held until the consumer takes it.
module inc_dec #(
    parameter int N = 4
) (
    input  logic [N-1:0] in,
    input  logic         mode,
    output logic [N-1:0] out,
    output logic         wrap
);
    always_comb begin
        out  = mode ? (in - N'(1)) : (in + N'(1));
        wrap = mode ? (in == '0) : (&in);
    end
endmodule

module inc_dec_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_in,
    input  logic         req0_mode,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_in,
    input  logic         req1_mode,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_out,
    output logic         res_id,
    output logic         res_wrap
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t       state, state_nxt;
    logic         ptr;
    logic         sel1;
    logic         grant;
    logic [N-1:0] op_in;
    logic         op_mode;
    logic [N-1:0] op_out;
    logic         op_wrap;

    // req1 wins when it is the only requester or when ptr favours it
    always_comb begin
        sel1       = req1_valid & (~req0_valid | ptr);
        grant      = (state == IDLE) & (req0_valid | req1_valid);
        req0_ready = (state == IDLE) & req0_valid & ~sel1;
        req1_ready = (state == IDLE) & sel1;
        op_in      = sel1 ? req1_in   : req0_in;
        op_mode    = sel1 ? req1_mode : req0_mode;
    end

    inc_dec #(.N(N)) u_inc_dec (
        .in   (op_in),
        .mode (op_mode),
        .out  (op_out),
        .wrap (op_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid | req1_valid) state_nxt = HOLD;
            HOLD:    if (res_ready)               state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= 1'b0;
            res_out  <= '0;
            res_id   <= 1'b0;
            res_wrap <= 1'b0;
        end else if (grant) begin
            ptr      <= ~sel1;
            res_out  <= op_out;
            res_id   <= sel1;
            res_wrap <= op_wrap;
        end
    end

    assign res_valid = (state == HOLD);
endmodule
